// File: rtl/gates_pkg.sv
// Shared constants for the gate-level tree blocks (zero detect and friends).
`timescale 1ns/10ps
package gates_pkg;

    // Propagation delay, in ns, given to every primitive gate in the tree blocks.
    localparam real GATE_DLY = 0.05;

    localparam int WORD_W   = 16;
    localparam int NIBBLE_W = 4;
    localparam int NIBBLES  = WORD_W / NIBBLE_W;

endpackage

// File: rtl/nor_16to1_dff_ar.sv
// D flip-flop with asynchronous active-low reset to 0.
`timescale 1ns/10ps
module dff_ar (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/nor_16to1.sv
// 16-bit all-zero detector: two-level NOR/AND gate tree plus a registered copy
// of the flag with a valid qualifier.
`timescale 1ns/10ps
module nor_16to1
    import gates_pkg::*;
#(
    parameter real GATE_DLY = gates_pkg::GATE_DLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        in_valid,
    output wire         zeroFlag,
    output logic        zero_q,
    output logic        valid_q
);

    wire [NIBBLES-1:0] nib_zero;
    logic              zero_d;
    logic              valid_d;

    // Each nibble NOR is 1 only when its four bits are all 0.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        nor #(GATE_DLY) u_nor (
            nib_zero[gi],
            in[NIBBLE_W*gi+3],
            in[NIBBLE_W*gi+2],
            in[NIBBLE_W*gi+1],
            in[NIBBLE_W*gi]
        );
    end

    and #(GATE_DLY) u_and (zeroFlag, nib_zero[0], nib_zero[1], nib_zero[2], nib_zero[3]);

    // Flag holds across idle cycles; valid only marks the cycle after a capture.
    always_comb begin
        zero_d  = zero_q;
        valid_d = in_valid;
        if (in_valid) begin
            zero_d = zeroFlag;
        end
    end

    dff_ar u_zero_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (zero_d),
        .q     (zero_q)
    );

    dff_ar u_valid_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (valid_d),
        .q     (valid_q)
    );

endmodule

// File: tb/tb_nor_16to1.sv
// Self-checking bench for nor_16to1 with a scoreboard of expected registered outputs.
`timescale 1ns/10ps
module tb_nor_16to1;

    typedef struct packed {
        logic zero;
        logic valid;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        in_valid;
    wire         zeroFlag;
    logic        zero_q;
    logic        valid_q;

    exp_t        sb[$];
    logic        model_zero;
    int          vectors;
    int          miscompares;

    nor_16to1 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .in_valid (in_valid),
        .zeroFlag (zeroFlag),
        .zero_q   (zero_q),
        .valid_q  (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one word at the falling edge, check the combinational flag once it
    // has settled, push the expected registered result and compare after the edge.
    task automatic cycle(input logic [15:0] v, input logic vld, input string tag);
        exp_t e;
        logic exp_flag;
        @(negedge clk);
        in       = v;
        in_valid = vld;
        exp_flag = (v == 16'h0000);
        #0.11;
        vectors++;
        if (zeroFlag !== exp_flag) begin
            miscompares++;
            $display("FAIL %s zeroFlag in=%h got %b want %b", tag, v, zeroFlag, exp_flag);
        end
        if (vld) model_zero = exp_flag;
        sb.push_back('{zero: model_zero, valid: vld});
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard empty got 0 entries want 1", tag);
        end else begin
            e = sb.pop_front();
            if (zero_q !== e.zero || valid_q !== e.valid) begin
                miscompares++;
                $display("FAIL %s regs in=%h got zero_q=%b valid_q=%b want %b %b",
                         tag, v, zero_q, valid_q, e.zero, e.valid);
            end
        end
        $display("%s in=%h vld=%b zeroFlag=%b zero_q=%b valid_q=%b",
                 tag, v, vld, zeroFlag, zero_q, valid_q);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in = 16'hFFFF;
        in_valid = 1'b1;
        model_zero = 1'b0;
        #1;
        vectors++;
        if (zero_q !== 1'b0 || valid_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got zero_q=%b valid_q=%b want 0 0", zero_q, valid_q);
        end
        in = 16'h0000;
        #1;
        vectors++;
        if (zeroFlag !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_zeroflag got %b want 1", zeroFlag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_zero_and_ones();
        cycle(16'h0000, 1'b1, "zero");
        cycle(16'hFFFF, 1'b1, "ones");
        cycle(16'h0000, 1'b1, "zero2");
    endtask

    task automatic test_walking_one();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 16'h0001 << i;
            cycle(v, 1'b1, "walk");
        end
    endtask

    task automatic test_sequential();
        // 100 ns per value, i.e. ten clock periods, with capture every cycle.
        for (int n = 0; n < 100; n++) begin
            for (int k = 0; k < 10; k++) begin
                cycle(16'(n), 1'b1, "seq");
            end
        end
    endtask

    task automatic test_hold();
        cycle(16'h0000, 1'b1, "hold_load");
        cycle(16'h0000, 1'b0, "hold_idle0");
        cycle(16'h0010, 1'b0, "hold_idle1");
        cycle(16'h0010, 1'b0, "hold_idle2");
        cycle(16'h0010, 1'b1, "hold_capture");
    endtask

    task automatic test_mid_reset();
        logic flag_before;
        cycle(16'h0000, 1'b1, "pre_reset");
        @(negedge clk);
        #2;
        flag_before = zeroFlag;
        rst_n = 1'b0;
        #0.5;
        vectors++;
        if (zero_q !== 1'b0 || valid_q !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset regs got zero_q=%b valid_q=%b want 0 0", zero_q, valid_q);
        end
        vectors++;
        if (zeroFlag !== 1'b1 || zeroFlag !== flag_before) begin
            miscompares++;
            $display("FAIL mid_reset zeroFlag got %b want 1", zeroFlag);
        end
        #1;
        rst_n = 1'b1;
        model_zero = 1'b0;
        sb.delete();
        $display("mid-stream reset pulse done");
        cycle(16'h0000, 1'b1, "post_reset");
        cycle(16'h1234, 1'b1, "b2b_a");
        cycle(16'h0000, 1'b1, "b2b_b");
        cycle(16'h8000, 1'b1, "b2b_c");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_zero_and_ones();
        test_walking_one();
        test_hold();
        test_mid_reset();
        test_sequential();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nor_16to1.md
NOR_16TO1 -- requirements
Module: nor_16to1

Interface
REQ-001 The module SHALL have parameter GATE_DLY, default 0.05 (ns, timescale 1ns/10ps), the propagation delay applied to every primitive gate.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in, input, 16 bits: the word to test for all-zero.
REQ-005 The module SHALL have port in_valid, input, 1 bit: qualifies `in` for capture into the registered path.
REQ-006 The module SHALL have port zeroFlag, output, 1 bit: combinational flag, 1 when in == 16'h0000.
REQ-007 The module SHALL have port zero_q, output, 1 bit: registered copy of zeroFlag.
REQ-008 The module SHALL have port valid_q, output, 1 bit: 1 when zero_q holds a captured result.

Function
REQ-009 zeroFlag SHALL equal NOR of in[15:0]: 1 if and only if all 16 bits are 0, for all 65536 input values.
REQ-010 zeroFlag SHALL be combinational, independent of clk, rst_n and in_valid.
REQ-011 zeroFlag SHALL settle within 2 x GATE_DLY (0.10 ns) of any change on `in`.
REQ-012 X or Z on any `in` bit SHALL give zeroFlag = X, except that any bit at 1 SHALL force zeroFlag = 0.
REQ-013 When in_valid = 1 at a rising clk, zero_q SHALL load zeroFlag and valid_q SHALL load 1.
  - Latency: exactly 1 cycle.
REQ-014 When in_valid = 0 at a rising clk, zero_q SHALL hold its value and valid_q SHALL load 0.
REQ-015 Back-to-back in_valid = 1 cycles SHALL each produce a result; there is no stall and no backpressure.
REQ-016 zero_q SHALL reflect the `in` value present at the sampling edge, not any later glitch.

Reset
REQ-017 While rst_n = 0, zero_q SHALL be 0 and valid_q SHALL be 0, asynchronously and without waiting for clk.
REQ-018 Reset assertion mid-stream SHALL discard any pending result.
REQ-019 After rst_n deasserts, the first rising clk with in_valid = 1 SHALL produce valid_q = 1 one cycle later.
REQ-020 Reset SHALL NOT affect zeroFlag.

Structure
REQ-021 The combinational path SHALL be built only from gate primitives of at most 4 inputs, each carrying delay GATE_DLY.
  - Stage 1: four 4-input NOR gates, one per nibble in[3:0], in[7:4], in[11:8], in[15:12].
  - Stage 2: one 4-input AND gate over the four NOR outputs.
REQ-022 The registered outputs SHALL use one reusable sub-module, dff_ar (D flip-flop, asynchronous active-low reset to 0), instantiated twice.
REQ-023 GATE_DLY SHALL be defined as a shared constant in the project package (gates_pkg) so zeroF and other tree-structured blocks use the same value.
REQ-024 No behavioural reduction operators SHALL appear in the combinational path.

Verification
REQ-025 The bench SHALL check: in = 16'h0000 -> zeroFlag = 1 after 0.10 ns; with in_valid = 1, next edge -> zero_q = 1, valid_q = 1.
REQ-026 The bench SHALL check: in = 16'hFFFF -> zeroFlag = 0, zero_q = 0 after the capturing edge.
REQ-027 The bench SHALL check: a walking single 1 over bits 0..15 (16'h0001 ... 16'h8000) -> zeroFlag = 0 for every bit, proving each nibble gate.
REQ-028 The bench SHALL check: in = 0..99 sequential, 100 ns each -> zeroFlag = 1 only for 0, else 0.
REQ-029 The bench SHALL check: rst_n pulsed low between clock edges while valid_q = 1 -> zero_q = 0 and valid_q = 0 immediately.
  - zeroFlag is unchanged by the reset pulse.
REQ-030 The bench SHALL check: in_valid = 0 with `in` changing from 0 to 16'h0010 -> zero_q holds its previous value and valid_q = 0.
